// File: rtl/lrsc_probe_guard.sv
// Coherence probe guard: stalls probes that hit the LR-reserved line and kills the
// reservation when a probe is forwarded onto it. Macro LRSC_PROBE_TIMEOUT_EN bounds HOLD to HOLD_MAX cycles.
module lrsc_probe_guard #(
  parameter int ADDR_W  = 34,
  parameter int PARAM_W = 2
`ifdef LRSC_PROBE_TIMEOUT_EN
  ,
  parameter int HOLD_MAX = 24
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               probe_in_valid,
  output logic               probe_in_ready,
  input  logic [ADDR_W-1:0]  probe_in_addr,
  input  logic [PARAM_W-1:0] probe_in_param,
  output logic               probe_out_valid,
  input  logic               probe_out_ready,
  output logic [ADDR_W-1:0]  probe_out_addr,
  output logic [PARAM_W-1:0] probe_out_param,
  input  logic               lrsc_valid,
  input  logic [ADDR_W-1:0]  lrsc_addr,
  output logic               invalidate,
  output logic               hold_active
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_FWD  = 2'd2
  } state_t;

  state_t state_r;
  logic   in_match_s;
  logic   out_match_s;
  logic   fire_s;
  logic   hold_exit_s;

`ifdef LRSC_PROBE_TIMEOUT_EN
  localparam logic [4:0] HOLD_LAST = 5'(HOLD_MAX - 1);
  logic [4:0] hold_cnt_r;

  // Cycles spent in HOLD for the current probe; cleared once the probe is handed off.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= 5'd0;
    end else if (state_r == ST_HOLD) begin
      hold_cnt_r <= hold_cnt_r + 5'd1;
    end else if (fire_s) begin
      hold_cnt_r <= 5'd0;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end
`endif

  // Reservation match against incoming / captured address, handshake and HOLD exit decode.
  always_comb begin
    in_match_s  = lrsc_valid & (probe_in_addr == lrsc_addr);
    out_match_s = lrsc_valid & (probe_out_addr == lrsc_addr);
    fire_s      = probe_out_valid & probe_out_ready;
`ifdef LRSC_PROBE_TIMEOUT_EN
    if (out_match_s && (hold_cnt_r != HOLD_LAST)) begin
      hold_exit_s = 1'b0;
    end else begin
      hold_exit_s = 1'b1;
    end
`else
    hold_exit_s = ~out_match_s;
`endif
  end

  // Forwarding onto a still-live reservation must break it so the pending SC fails.
  assign invalidate = fire_s & out_match_s;

  // Probe FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      probe_in_ready  <= 1'b1;
      probe_out_valid <= 1'b0;
      hold_active     <= 1'b0;
      probe_out_addr  <= {ADDR_W{1'b0}};
      probe_out_param <= {PARAM_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (probe_in_valid && probe_in_ready) begin
            probe_out_addr  <= probe_in_addr;
            probe_out_param <= probe_in_param;
            probe_in_ready  <= 1'b0;
            if (in_match_s) begin
              state_r     <= ST_HOLD;
              hold_active <= 1'b1;
            end else begin
              state_r         <= ST_FWD;
              probe_out_valid <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_exit_s) begin
            state_r         <= ST_FWD;
            hold_active     <= 1'b0;
            probe_out_valid <= 1'b1;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_FWD: begin
          // A reservation appearing now does not re-hold; it only arms invalidate.
          if (probe_out_ready) begin
            state_r         <= ST_IDLE;
            probe_out_valid <= 1'b0;
            probe_in_ready  <= 1'b1;
          end else begin
            state_r <= ST_FWD;
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          probe_in_ready  <= 1'b1;
          probe_out_valid <= 1'b0;
          hold_active     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lrsc_probe_guard.sv
// Self-checking bench for lrsc_probe_guard: directed scenarios plus randomized probes
// checked against a transaction-level timing model (hold length, fire cycle, invalidate).
module tb_lrsc_probe_guard;
  localparam int ADDR_W  = 34;
  localparam int PARAM_W = 2;
`ifdef LRSC_PROBE_TIMEOUT_EN
  localparam int HMAX = 4;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               probe_in_valid = 1'b0;
  logic               probe_in_ready;
  logic [ADDR_W-1:0]  probe_in_addr = '0;
  logic [PARAM_W-1:0] probe_in_param = '0;
  logic               probe_out_valid;
  logic               probe_out_ready = 1'b0;
  logic [ADDR_W-1:0]  probe_out_addr;
  logic [PARAM_W-1:0] probe_out_param;
  logic               lrsc_valid = 1'b0;
  logic [ADDR_W-1:0]  lrsc_addr = '0;
  logic               invalidate;
  logic               hold_active;

  int n_tests = 0;
  int n_fail  = 0;

  lrsc_probe_guard #(
    .ADDR_W(ADDR_W),
    .PARAM_W(PARAM_W)
`ifdef LRSC_PROBE_TIMEOUT_EN
    ,
    .HOLD_MAX(HMAX)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .probe_in_valid(probe_in_valid),
    .probe_in_ready(probe_in_ready),
    .probe_in_addr(probe_in_addr),
    .probe_in_param(probe_in_param),
    .probe_out_valid(probe_out_valid),
    .probe_out_ready(probe_out_ready),
    .probe_out_addr(probe_out_addr),
    .probe_out_param(probe_out_param),
    .lrsc_valid(lrsc_valid),
    .lrsc_addr(lrsc_addr),
    .invalidate(invalidate),
    .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  // HOLD lasts one cycle per matching cycle plus the cycle that sees the miss,
  // capped at HMAX cycles when the timeout is built in.
  function automatic int hold_len(input int k);
`ifdef LRSC_PROBE_TIMEOUT_EN
    return (k + 1 < HMAX) ? k + 1 : HMAX;
`else
    return k + 1;
`endif
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'({$urandom(), $urandom()});
  endfunction

  // One complete probe transaction.  res_match: reservation covers the probe at accept;
  // k: further cycles the reservation keeps matching; d: cycles probe_out_ready stays low;
  // fire_match: reservation covers the line while forwarded.
  task automatic do_probe(input logic [ADDR_W-1:0] a, input logic [PARAM_W-1:0] p,
                          input bit res_match, input int k, input int d,
                          input bit fire_match, input string tag);
    logic [ADDR_W-1:0] other;
    logic [3:0]        obs;
    logic [3:0]        exp;
    int                h;
    int                hold_seen;
    other     = a ^ {{(ADDR_W-1){1'b0}}, 1'b1};
    h         = res_match ? hold_len(k) : 0;
    hold_seen = 0;

    @(negedge clk);
    probe_in_valid  = 1'b1;
    probe_in_addr   = a;
    probe_in_param  = p;
    probe_out_ready = 1'($urandom());
    if (res_match) begin
      lrsc_valid = 1'b1; lrsc_addr = a;
    end else if ($urandom_range(0, 1) == 0) begin
      lrsc_valid = 1'b0; lrsc_addr = a;
    end else begin
      lrsc_valid = 1'b1; lrsc_addr = other;
    end
    #1;
    obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
    n_tests++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s accept: rdy/vld/hold/inv got %b want 1000", tag, obs);
    end

    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      probe_in_valid  = 1'($urandom());
      probe_in_addr   = rand_addr();
      probe_out_ready = 1'($urandom());
      if (i < k) begin
        lrsc_valid = 1'b1; lrsc_addr = a;
      end else if ($urandom_range(0, 1) == 0) begin
        lrsc_valid = 1'b0;
      end else begin
        lrsc_valid = 1'b1; lrsc_addr = other;
      end
      #1;
      if (hold_active === 1'b1) hold_seen++;
      obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
      n_tests++;
      if (obs !== 4'b0010) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: rdy/vld/hold/inv got %b want 0010", tag, i, obs);
      end
    end
    if (res_match) begin
      n_tests++;
      if (hold_seen != h) begin
        n_fail++;
        $display("FAIL %s hold_count: got %0d want %0d", tag, hold_seen, h);
      end
    end

    for (int j = 0; j <= d; j++) begin
      @(negedge clk);
      probe_in_valid  = 1'($urandom());
      probe_in_addr   = rand_addr();
      probe_in_param  = PARAM_W'($urandom());
      probe_out_ready = (j == d);
      if (fire_match) begin
        lrsc_valid = 1'b1; lrsc_addr = a;
      end else if ($urandom_range(0, 1) == 0) begin
        lrsc_valid = 1'b0; lrsc_addr = a;
      end else begin
        lrsc_valid = 1'b1; lrsc_addr = other;
      end
      #1;
      exp = {3'b010, ((j == d) && fire_match)};
      obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s fwd[%0d]: rdy/vld/hold/inv got %b want %b", tag, j, obs, exp);
      end
      n_tests++;
      if ({probe_out_addr, probe_out_param} !== {a, p}) begin
        n_fail++;
        $display("FAIL %s fwd_data[%0d]: addr %h param %h want %h %h",
                 tag, j, probe_out_addr, probe_out_param, a, p);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    @(negedge clk);
    reset = 1'b1; probe_in_valid = 1'b1; probe_in_addr = 34'h2A;
    lrsc_valid = 1'b1; lrsc_addr = 34'h2A;
    @(negedge clk);
    reset = 1'b0; probe_in_valid = 1'b0; lrsc_valid = 1'b0;
    #1;
    obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
    n_tests++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy/vld/hold/inv got %b want 1000", obs);
    end
    n_tests++;
    if ({probe_out_addr, probe_out_param} !== {ADDR_W + PARAM_W{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_data: addr %h param %h want 0 0", probe_out_addr, probe_out_param);
    end
  endtask

  task automatic test_forward();
    do_probe(34'h1000, 2'b01, 1'b0, 0, 0, 1'b0, "forward");
  endtask

  task automatic test_hold();
    do_probe(34'h2A, 2'b10, 1'b1, 9, 0, 1'b0, "hold10");
  endtask

  task automatic test_no_match();
    do_probe(34'h2B, 2'b11, 1'b0, 0, 0, 1'b0, "no_match");
  endtask

  task automatic test_long_hold();
    do_probe(34'h2A, 2'b00, 1'b1, 20, 0, 1'b1, "long_hold");
  endtask

  task automatic test_late_reservation();
    do_probe(34'h3C0, 2'b01, 1'b0, 0, 2, 1'b1, "late_live");
  endtask

  task automatic test_back_to_back();
    do_probe(34'h155, 2'b10, 1'b0, 0, 5, 1'b0, "backpressure");
    do_probe(34'h2AA, 2'b01, 1'b0, 0, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_in_hold();
    logic [3:0] obs;
    @(negedge clk);
    probe_in_valid = 1'b1; probe_in_addr = 34'h2A; probe_in_param = 2'b11;
    lrsc_valid = 1'b1; lrsc_addr = 34'h2A; probe_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      probe_in_valid = 1'b0;
      #1;
      obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
      n_tests++;
      if (obs !== 4'b0010) begin
        n_fail++;
        $display("FAIL rst_hold pre: rdy/vld/hold/inv got %b want 0010", obs);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lrsc_valid = 1'b0;
    #1;
    obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
    n_tests++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_hold post: rdy/vld/hold/inv got %b want 1000", obs);
    end
    n_tests++;
    if ({probe_out_addr, probe_out_param} !== {ADDR_W + PARAM_W{1'b0}}) begin
      n_fail++;
      $display("FAIL rst_hold data: addr %h param %h want 0 0", probe_out_addr, probe_out_param);
    end
    @(negedge clk);
    #1;
    obs = {probe_in_ready, probe_out_valid, hold_active, invalidate};
    n_tests++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_hold dropped: rdy/vld/hold/inv got %b want 1000", obs);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_probe(rand_addr(), PARAM_W'($urandom()), 1'($urandom()),
               $urandom_range(0, 12), $urandom_range(0, 4), 1'($urandom()), "random");
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_hold();
    test_no_match();
    test_long_hold();
    test_late_reservation();
    test_back_to_back();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
